l2_cache_dm_param: RTL and testbench
====================================

Name: l2_cache_dm_param

Overview:
Parametrised direct-mapped, write-back, write-allocate L2 cache between the L1/bus master (Wishbone slave side), the SRAM data store and DDR main memory. It is the successor to the fixed single-geometry L2: line width, set count and address width are parameters. Tags, valid bits and dirty bits live in on-chip registers, and SRAM holds line data only. It adds correct partial-write miss merging and a full-cache flush command.

Parameters:
ADDR_W, 32, byte address width on all interfaces
LINE_W, 512, line width in bits; power of two, minimum 64; DM_W = LINE_W/8 byte-enable bits
INDEX_W, 6, log2(number of sets); OFF_W = log2(LINE_W/8); TAG_W = ADDR_W-INDEX_W-OFF_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ws_addr  in  ADDR_W  request byte address (offset bits ignored)
ws_din  in  LINE_W  write line data
ws_dm  in  DM_W  byte enables, 1 = write byte
ws_stb  in  1  request strobe, held until ws_ack
ws_we  in  1  1 = write, 0 = read
ws_ack  out  1  one-cycle completion pulse
ws_dout  out  LINE_W  read data, valid while ws_ack=1
flush_req  in  1  one-cycle flush command pulse
flush_busy  out  1  high from flush acceptance until the flush completes
ws_DDRaddr  out  ADDR_W  line-aligned DDR address
ws_DDRdin  out  LINE_W  write-back data
ws_DDRdm  out  DM_W  all ones on write-back, zero on fill
ws_DDRcyc  out  1  equals ws_DDRstb
ws_DDRstb  out  1  DDR request, held until ws_DDRack
ws_DDRwe  out  1  1 = write-back
ws_DDRack  in  1  DDR completion
ws_DDRdout  in  LINE_W  fill data, valid with ws_DDRack
ws_SRAMaddr  out  ADDR_W  {0, index, OFF_W zeros}
ws_SRAMdin  out  LINE_W  line data to SRAM
ws_SRAMdm  out  DM_W  SRAM byte enables
ws_SRAMstb  out  1  SRAM request, held until ws_SRAMack
ws_SRAMwe  out  1  SRAM write
ws_SRAMack  in  1  SRAM completion
ws_SRAMdout  in  LINE_W  SRAM read data, valid with ws_SRAMack

Behaviour:
- Single clock clk; synchronous active-high reset rst. Reset has priority over everything, including mid-transaction. Reset values: all strobes, we, ws_ack, flush_busy = 0; all addr/data/dm outputs = 0; all valid and dirty bits = 0; FSM = IDLE. Dirty data is discarded on reset, by design.
- Address split: tag = addr[ADDR_W-1 -: TAG_W], index = addr[OFF_W +: INDEX_W].
- FSM states: IDLE, LOOKUP, HIT_RD, VICT_RD, WB, FILL, SRAM_WR, FLUSH_CHK, FLUSH_RD, FLUSH_WB.
- IDLE: ignores ws_stb and flush_req while ws_ack=1, giving one dead cycle. flush_req wins over ws_stb when both arrive in the same cycle. ws_stb latches addr/din/dm/we and goes to LOOKUP. flush_req sets flush_busy, sets set counter = 0 and goes to FLUSH_CHK.
- LOOKUP (1 cycle): hit = valid[idx] && tag match.
  - Read hit -> HIT_RD: SRAM read; on ack, ws_dout = ws_SRAMdout, ws_ack = 1 next cycle -> IDLE. Read-hit latency from stb sample to ack = 3 cycles + SRAM latency.
  - Write hit -> SRAM_WR with dm = latched dm, din = latched din; dirty = 1; ws_ack pulses on SRAM ack.
  - Miss with valid && dirty -> VICT_RD, otherwise -> FILL.
- VICT_RD: SRAM reads the victim line, then WB: DDR write to {old tag, idx, 0}, dm all ones. On DDR ack -> FILL.
- FILL: DDR read of the request line address. On ack, the line is merged: byte b = ws_dm[b] ? din : DDRdout on a write, DDRdout on a read. The merged line goes to SRAM_WR with dm all ones. tag/valid are updated, dirty = we. For a read, ws_dout = DDRdout.
- SRAM_WR: on ws_SRAMack, ws_ack = 1 for one cycle -> IDLE. ws_ack never precedes SRAM write completion.
- Flush: for set s = 0 .. 2^INDEX_W-1 in ascending order, a valid && dirty set goes FLUSH_RD then FLUSH_WB; every set is then invalidated. After the last set, flush_busy = 0 -> IDLE. A flush does not pulse ws_ack.
- Every external strobe is held constant, with stable addr/data, until its ack. Only one of SRAM and DDR is strobed at a time.

Optional Feature:
L2CACHE_STATS_EN: when defined, adds outputs stat_hit [31:0] and stat_miss [31:0]. Each is incremented once per request in LOOKUP, wraps at 2^32 and is cleared by rst; flushes are not counted. When undefined, these ports and counters do not exist.

Test Plan:
- Defaults; read 0x003FFFC0 cold -> one DDR read at 0x003FFFC0; DDRdout = {16{0x12345678}} -> SRAM write addr 0x00000FC0, dm all ones; ws_ack with dout = {16{0x12345678}}.
- Re-read 0x003FFFC0 -> no DDR strobe; SRAM read at 0xFC0; dout = {16{0x12345678}}.
- Write 0x003FFFC0, dm all ones, din = {16{0x87654321}}, then read 0x007FFFC0 -> DDR write at 0x003FFFC0 with {16{0x87654321}}, then DDR read at 0x007FFFC0; fill {16{0x5A5A5A5A}} -> dout = that.
- Write miss 0x00001000, dm = 0xF, din low word 0xDEADBEEF, fill {16{0x5A5A5A5A}} -> SRAM line has low word DEADBEEF, the rest 5A. Re-read returns the same with no DDR access.
- Dirty sets 3 and 9, flush_req -> exactly two DDR writes, index 3 then 9; flush_busy falls; next read of either line misses.
- rst asserted during FILL -> next cycle all strobes and ws_ack = 0; a subsequent read of a previously cached address misses.

Source files
------------

// File: rtl/l2_cache_dm_param.sv
// Direct-mapped write-back/write-allocate L2 with register tags, SRAM data store, DDR backing and full flush.
// Latency: read hit = 3 cycles + SRAM latency; misses add DDR fill (and victim write-back when dirty).
// Backpressure: every SRAM/DDR strobe is held with stable addr/data until ack; ws_stb/flush_req ignored while busy.
// Optional: define L2CACHE_STATS_EN to add stat_hit/stat_miss lookup counters.
module l2_cache_dm_param #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 512,
   parameter int INDEX_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   ws_addr,
   input  logic [LINE_W-1:0]   ws_din,
   input  logic [LINE_W/8-1:0] ws_dm,
   input  logic                ws_stb,
   input  logic                ws_we,
   output logic                ws_ack,
   output logic [LINE_W-1:0]   ws_dout,
   input  logic                flush_req,
   output logic                flush_busy,
   output logic [ADDR_W-1:0]   ws_DDRaddr,
   output logic [LINE_W-1:0]   ws_DDRdin,
   output logic [LINE_W/8-1:0] ws_DDRdm,
   output logic                ws_DDRcyc,
   output logic                ws_DDRstb,
   output logic                ws_DDRwe,
   input  logic                ws_DDRack,
   input  logic [LINE_W-1:0]   ws_DDRdout,
   output logic [ADDR_W-1:0]   ws_SRAMaddr,
   output logic [LINE_W-1:0]   ws_SRAMdin,
   output logic [LINE_W/8-1:0] ws_SRAMdm,
   output logic                ws_SRAMstb,
   output logic                ws_SRAMwe,
   input  logic                ws_SRAMack,
   input  logic [LINE_W-1:0]   ws_SRAMdout
`ifdef L2CACHE_STATS_EN
   ,
   output logic [31:0]         stat_hit,
   output logic [31:0]         stat_miss
`endif
);

   localparam int DM_W  = LINE_W / 8;
   localparam int OFF_W = $clog2(DM_W);
   localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
   localparam int SETS  = 1 << INDEX_W;

   typedef enum logic [3:0] {
      S_IDLE, S_LOOKUP, S_HIT_RD, S_VICT_RD, S_WB, S_FILL, S_SRAM_WR,
      S_FLUSH_CHK, S_FLUSH_RD, S_FLUSH_WB
   } state_t;

   state_t             state_q;
   logic [TAG_W-1:0]   req_tag_q;
   logic [INDEX_W-1:0] req_idx_q;
   logic [LINE_W-1:0]  req_din_q;
   logic [DM_W-1:0]    req_dm_q;
   logic               req_we_q;
   logic [TAG_W-1:0]   tag_q [SETS];
   logic [SETS-1:0]    valid_q;
   logic [SETS-1:0]    dirty_q;
   logic [INDEX_W-1:0] fidx_q;

   logic               hit;
   logic [LINE_W-1:0]  merged;
   logic               unused_addr_bits;

   // Byte offset inside a line never selects anything: whole lines move on every interface.
   assign unused_addr_bits = ^ws_addr[OFF_W-1:0];
   assign ws_DDRcyc = ws_DDRstb;
   assign hit = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] i);
      return {t, i, {OFF_W{1'b0}}};
   endfunction

   function automatic logic [ADDR_W-1:0] sram_addr(input logic [INDEX_W-1:0] i);
      logic [ADDR_W-1:0] a;
      a = '0;
      a[OFF_W +: INDEX_W] = i;
      return a;
   endfunction

   // Fill merge: on a write miss the enabled request bytes override the line fetched from DDR.
   always_comb begin
      merged = ws_DDRdout;
      for (int b = 0; b < DM_W; b++) begin
         if (req_we_q && req_dm_q[b]) merged[b*8 +: 8] = req_din_q[b*8 +: 8];
      end
   end

   // Main controller: request lookup, victim write-back, fill, SRAM update and set-by-set flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_tag_q   <= '0;
         req_idx_q   <= '0;
         req_din_q   <= '0;
         req_dm_q    <= '0;
         req_we_q    <= 1'b0;
         valid_q     <= '0;
         dirty_q     <= '0;
         fidx_q      <= '0;
         ws_ack      <= 1'b0;
         ws_dout     <= '0;
         flush_busy  <= 1'b0;
         ws_DDRaddr  <= '0;
         ws_DDRdin   <= '0;
         ws_DDRdm    <= '0;
         ws_DDRstb   <= 1'b0;
         ws_DDRwe    <= 1'b0;
         ws_SRAMaddr <= '0;
         ws_SRAMdin  <= '0;
         ws_SRAMdm   <= '0;
         ws_SRAMstb  <= 1'b0;
         ws_SRAMwe   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ws_ack) begin
                  ws_ack <= 1'b0;          // dead cycle lets the master drop ws_stb
               end else if (flush_req) begin
                  flush_busy <= 1'b1;
                  fidx_q     <= '0;
                  state_q    <= S_FLUSH_CHK;
               end else if (ws_stb) begin
                  req_tag_q <= ws_addr[ADDR_W-1 -: TAG_W];
                  req_idx_q <= ws_addr[OFF_W +: INDEX_W];
                  req_din_q <= ws_din;
                  req_dm_q  <= ws_dm;
                  req_we_q  <= ws_we;
                  state_q   <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               ws_SRAMaddr <= sram_addr(req_idx_q);
               if (hit) begin
                  ws_SRAMstb <= 1'b1;
                  if (req_we_q) begin
                     ws_SRAMwe           <= 1'b1;
                     ws_SRAMdin          <= req_din_q;
                     ws_SRAMdm           <= req_dm_q;
                     dirty_q[req_idx_q]  <= 1'b1;
                     state_q             <= S_SRAM_WR;
                  end else begin
                     ws_SRAMwe <= 1'b0;
                     ws_SRAMdm <= '0;
                     state_q   <= S_HIT_RD;
                  end
               end else if (valid_q[req_idx_q] && dirty_q[req_idx_q]) begin
                  ws_SRAMstb <= 1'b1;
                  ws_SRAMwe  <= 1'b0;
                  ws_SRAMdm  <= '0;
                  state_q    <= S_VICT_RD;
               end else begin
                  state_q <= S_FILL;
               end
            end
            S_HIT_RD: begin
               if (ws_SRAMack) begin
                  ws_SRAMstb <= 1'b0;
                  ws_dout    <= ws_SRAMdout;
                  ws_ack     <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            S_VICT_RD: begin
               if (ws_SRAMack) begin
                  ws_SRAMstb <= 1'b0;
                  ws_DDRstb  <= 1'b1;
                  ws_DDRwe   <= 1'b1;
                  ws_DDRaddr <= line_addr(tag_q[req_idx_q], req_idx_q);
                  ws_DDRdin  <= ws_SRAMdout;
                  ws_DDRdm   <= '1;
                  state_q    <= S_WB;
               end
            end
            S_WB: begin
               if (ws_DDRack) begin
                  ws_DDRstb <= 1'b0;
                  ws_DDRwe  <= 1'b0;
                  state_q   <= S_FILL;
               end
            end
            S_FILL: begin
               if (!ws_DDRstb) begin
                  // DDR strobe is idle on entry, so the fill read is launched from here
                  ws_DDRstb  <= 1'b1;
                  ws_DDRwe   <= 1'b0;
                  ws_DDRaddr <= line_addr(req_tag_q, req_idx_q);
                  ws_DDRdm   <= '0;
               end else if (ws_DDRack) begin
                  ws_DDRstb          <= 1'b0;
                  ws_SRAMstb         <= 1'b1;
                  ws_SRAMwe          <= 1'b1;
                  ws_SRAMaddr        <= sram_addr(req_idx_q);
                  ws_SRAMdin         <= merged;
                  ws_SRAMdm          <= '1;
                  tag_q[req_idx_q]   <= req_tag_q;
                  valid_q[req_idx_q] <= 1'b1;
                  dirty_q[req_idx_q] <= req_we_q;
                  if (!req_we_q) ws_dout <= ws_DDRdout;
                  state_q            <= S_SRAM_WR;
               end
            end
            S_SRAM_WR: begin
               if (ws_SRAMack) begin
                  ws_SRAMstb <= 1'b0;
                  ws_SRAMwe  <= 1'b0;
                  ws_ack     <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            S_FLUSH_CHK: begin
               if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
                  ws_SRAMstb  <= 1'b1;
                  ws_SRAMwe   <= 1'b0;
                  ws_SRAMdm   <= '0;
                  ws_SRAMaddr <= sram_addr(fidx_q);
                  state_q     <= S_FLUSH_RD;
               end else begin
                  valid_q[fidx_q] <= 1'b0;
                  dirty_q[fidx_q] <= 1'b0;
                  if (&fidx_q) begin
                     flush_busy <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     fidx_q <= fidx_q + 1'b1;
                  end
               end
            end
            S_FLUSH_RD: begin
               if (ws_SRAMack) begin
                  ws_SRAMstb <= 1'b0;
                  ws_DDRstb  <= 1'b1;
                  ws_DDRwe   <= 1'b1;
                  ws_DDRaddr <= line_addr(tag_q[fidx_q], fidx_q);
                  ws_DDRdin  <= ws_SRAMdout;
                  ws_DDRdm   <= '1;
                  state_q    <= S_FLUSH_WB;
               end
            end
            S_FLUSH_WB: begin
               if (ws_DDRack) begin
                  ws_DDRstb       <= 1'b0;
                  ws_DDRwe        <= 1'b0;
                  valid_q[fidx_q] <= 1'b0;
                  dirty_q[fidx_q] <= 1'b0;
                  if (&fidx_q) begin
                     flush_busy <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     fidx_q  <= fidx_q + 1'b1;
                     state_q <= S_FLUSH_CHK;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef L2CACHE_STATS_EN
   // One hit or miss count per request lookup; flush traffic never passes LOOKUP.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hit  <= '0;
         stat_miss <= '0;
      end else if (state_q == S_LOOKUP) begin
         if (hit) stat_hit  <= stat_hit + 32'd1;
         else     stat_miss <= stat_miss + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_cache_dm_param.sv
// Bench for l2_cache_dm_param: vector table of requests, SRAM/DDR behavioural models,
// scoreboard for ws_ack/ws_dout, plus flush and reset-during-fill sequences.
module tb_l2_cache_dm_param;
   localparam int ADDR_W = 32, LINE_W = 512, INDEX_W = 6, DM_W = 64, OFF_W = 6;
   typedef logic [LINE_W-1:0] line_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, ws_stb = 1'b0, ws_we = 1'b0, flush_req = 1'b0;
   logic [ADDR_W-1:0] ws_addr = '0;
   line_t ws_din = '0;
   logic [DM_W-1:0] ws_dm = '0;
   logic ws_ack, flush_busy, ws_DDRcyc, ws_DDRstb, ws_DDRwe, ws_SRAMstb, ws_SRAMwe;
   line_t ws_dout, ws_DDRdin, ws_SRAMdin;
   logic [ADDR_W-1:0] ws_DDRaddr, ws_SRAMaddr;
   logic [DM_W-1:0] ws_DDRdm, ws_SRAMdm;
   logic ddr_ack_r = 1'b0, sram_ack_r = 1'b0;
   line_t ddr_dout_r = '0, sram_dout_r = '0;

   l2_cache_dm_param dut (
      .clk(clk), .rst(rst), .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
      .ws_stb(ws_stb), .ws_we(ws_we), .ws_ack(ws_ack), .ws_dout(ws_dout),
      .flush_req(flush_req), .flush_busy(flush_busy),
      .ws_DDRaddr(ws_DDRaddr), .ws_DDRdin(ws_DDRdin), .ws_DDRdm(ws_DDRdm),
      .ws_DDRcyc(ws_DDRcyc), .ws_DDRstb(ws_DDRstb), .ws_DDRwe(ws_DDRwe),
      .ws_DDRack(ddr_ack_r), .ws_DDRdout(ddr_dout_r),
      .ws_SRAMaddr(ws_SRAMaddr), .ws_SRAMdin(ws_SRAMdin), .ws_SRAMdm(ws_SRAMdm),
      .ws_SRAMstb(ws_SRAMstb), .ws_SRAMwe(ws_SRAMwe),
      .ws_SRAMack(sram_ack_r), .ws_SRAMdout(sram_dout_r)
   );

   int total = 0, bad = 0;

   task automatic chk(input string nm, input line_t act, input line_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- SRAM model (ack 2 cycles after strobe) ----------------
   line_t sram_mem [64];
   int s_cnt = 0, s_wr_n = 0;
   logic [ADDR_W-1:0] s_last_addr = '0;
   logic [DM_W-1:0] s_last_dm = '0;
   initial for (int i = 0; i < 64; i++) sram_mem[i] = '0;
   always @(posedge clk) begin
      sram_ack_r <= 1'b0;
      if (ws_SRAMstb && !sram_ack_r) begin
         if (s_cnt == 1) begin
            s_cnt       <= 0;
            sram_ack_r  <= 1'b1;
            s_last_addr <= ws_SRAMaddr;
            if (ws_SRAMwe) begin
               for (int b = 0; b < DM_W; b++)
                  if (ws_SRAMdm[b]) sram_mem[ws_SRAMaddr[OFF_W +: INDEX_W]][b*8 +: 8] <= ws_SRAMdin[b*8 +: 8];
               s_wr_n    <= s_wr_n + 1;
               s_last_dm <= ws_SRAMdm;
            end else begin
               sram_dout_r <= sram_mem[ws_SRAMaddr[OFF_W +: INDEX_W]];
            end
         end else s_cnt <= s_cnt + 1;
      end else if (!ws_SRAMstb) s_cnt <= 0;
   end

   // ---------------- DDR model (ack 3 cycles after strobe) ----------------
   line_t fill_data = '0;
   int d_cnt = 0;
   logic [ADDR_W-1:0] dwr_addr_q[$], drd_addr_q[$];
   line_t dwr_dat_q[$];
   always @(posedge clk) begin
      ddr_ack_r <= 1'b0;
      if (ws_DDRstb && !ddr_ack_r) begin
         if (d_cnt == 2) begin
            d_cnt     <= 0;
            ddr_ack_r <= 1'b1;
            if (ws_DDRwe) begin
               dwr_addr_q.push_back(ws_DDRaddr);
               dwr_dat_q.push_back(ws_DDRdin);
            end else begin
               drd_addr_q.push_back(ws_DDRaddr);
               ddr_dout_r <= fill_data;
            end
         end else d_cnt <= d_cnt + 1;
      end else if (!ws_DDRstb) d_cnt <= 0;
   end

   // ---------------- scoreboard / protocol monitor ----------------
   typedef struct { logic is_rd; line_t dout; } sb_t;
   sb_t sb_q[$];
   sb_t sb_e;
   int ack_n = 0;
   logic prev_ack = 1'b0;
   always @(negedge clk) begin
      if (ws_ack === 1'b1) begin
         ack_n++;
         if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack: got ack with no request outstanding");
         end else begin
            sb_e = sb_q.pop_front();
            if (sb_e.is_rd) chk("rd_dout", ws_dout, sb_e.dout);
         end
         if (prev_ack === 1'b1) begin
            total++; bad++;
            $display("FAIL ack_width: ws_ack high 2 cycles, want 1");
         end
      end
      prev_ack = ws_ack;
      if (ws_DDRstb === 1'b1 || ws_SRAMstb === 1'b1) begin
         chk("one_strobe", line_t'(ws_DDRstb & ws_SRAMstb), '0);
         chk("cyc_eq_stb", line_t'(ws_DDRcyc), line_t'(ws_DDRstb));
      end
   end

   task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input line_t din,
                         input logic [DM_W-1:0] dm, input line_t exp_dout);
      sb_t e;
      int n;
      e.is_rd = !we;
      e.dout  = exp_dout;
      sb_q.push_back(e);
      @(negedge clk);
      ws_stb = 1'b1; ws_we = we; ws_addr = a; ws_din = din; ws_dm = dm;
      n = 0;
      while (ws_ack !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (ws_ack !== 1'b1) begin
         bad++;
         $display("FAIL req_timeout: addr %h no ack after %0d cycles, want ack", a, n);
         if (sb_q.size() > 0) void'(sb_q.pop_back());
      end
      ws_stb = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic we; logic [ADDR_W-1:0] addr; line_t din; logic [DM_W-1:0] dm; line_t fill; line_t dout;
      int wb_n; logic [ADDR_W-1:0] wb_addr; line_t wb_dat; int rd_n; logic [ADDR_W-1:0] rd_addr;
      int swr_n; logic [ADDR_W-1:0] s_addr; logic [DM_W-1:0] s_dm; logic chk_line; line_t line;
   } vec_t;
   localparam int NV = 8;
   vec_t vec [NV];

   initial begin : main
      line_t L12, L87, L5A, L77, L11, LA, LB, LC, LD, LE, din4, m4, m6;
      logic [DM_W-1:0] ALL1;
      int wr0, rd0, sw0, a0, n;
      L12 = {16{32'h12345678}}; L87 = {16{32'h87654321}}; L5A = {16{32'h5A5A5A5A}};
      L77 = {64{8'h77}}; L11 = {64{8'h11}}; LA = {64{8'hA1}}; LB = {64{8'hB2}};
      LC = {64{8'hC3}}; LD = {64{8'hD4}}; LE = {64{8'hE5}}; ALL1 = '1;
      din4 = L11; din4[31:0] = 32'hDEADBEEF;
      m4 = L5A;   m4[31:0] = 32'hDEADBEEF;
      m6 = m4;    m6[63:32] = 32'h77777777;
      vec[0] = '{we:0, addr:32'h003FFFC0, din:'0, dm:'0, fill:L12, dout:L12, wb_n:0, wb_addr:'0, wb_dat:'0,
                 rd_n:1, rd_addr:32'h003FFFC0, swr_n:1, s_addr:32'hFC0, s_dm:ALL1, chk_line:1, line:L12};
      vec[1] = '{we:0, addr:32'h003FFFC0, din:'0, dm:'0, fill:L5A, dout:L12, wb_n:0, wb_addr:'0, wb_dat:'0,
                 rd_n:0, rd_addr:'0, swr_n:0, s_addr:32'hFC0, s_dm:'0, chk_line:0, line:'0};
      vec[2] = '{we:1, addr:32'h003FFFC0, din:L87, dm:ALL1, fill:L5A, dout:'0, wb_n:0, wb_addr:'0, wb_dat:'0,
                 rd_n:0, rd_addr:'0, swr_n:1, s_addr:32'hFC0, s_dm:ALL1, chk_line:1, line:L87};
      vec[3] = '{we:0, addr:32'h007FFFC0, din:'0, dm:'0, fill:L5A, dout:L5A, wb_n:1, wb_addr:32'h003FFFC0, wb_dat:L87,
                 rd_n:1, rd_addr:32'h007FFFC0, swr_n:1, s_addr:32'hFC0, s_dm:ALL1, chk_line:1, line:L5A};
      vec[4] = '{we:1, addr:32'h00001000, din:din4, dm:64'hF, fill:L5A, dout:'0, wb_n:0, wb_addr:'0, wb_dat:'0,
                 rd_n:1, rd_addr:32'h00001000, swr_n:1, s_addr:32'h0, s_dm:ALL1, chk_line:1, line:m4};
      vec[5] = '{we:0, addr:32'h00001000, din:'0, dm:'0, fill:L12, dout:m4, wb_n:0, wb_addr:'0, wb_dat:'0,
                 rd_n:0, rd_addr:'0, swr_n:0, s_addr:32'h0, s_dm:'0, chk_line:0, line:'0};
      vec[6] = '{we:1, addr:32'h00001000, din:L77, dm:64'hF0, fill:L12, dout:'0, wb_n:0, wb_addr:'0, wb_dat:'0,
                 rd_n:0, rd_addr:'0, swr_n:1, s_addr:32'h0, s_dm:64'hF0, chk_line:1, line:m6};
      vec[7] = '{we:0, addr:32'h00001000, din:'0, dm:'0, fill:L12, dout:m6, wb_n:0, wb_addr:'0, wb_dat:'0,
                 rd_n:0, rd_addr:'0, swr_n:0, s_addr:32'h0, s_dm:'0, chk_line:0, line:'0};

      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ack", line_t'(ws_ack), '0);
      chk("rst_busy", line_t'(flush_busy), '0);
      chk("rst_ddr_stb_we", line_t'({ws_DDRstb, ws_DDRwe}), '0);
      chk("rst_sram_stb_we", line_t'({ws_SRAMstb, ws_SRAMwe}), '0);
      chk("rst_addrs", line_t'({ws_DDRaddr, ws_SRAMaddr}), '0);
      chk("rst_dms", line_t'({ws_DDRdm, ws_SRAMdm}), '0);

      for (int i = 0; i < NV; i++) begin
         wr0 = dwr_addr_q.size(); rd0 = drd_addr_q.size(); sw0 = s_wr_n;
         fill_data = vec[i].fill;
         do_req(vec[i].we, vec[i].addr, vec[i].din, vec[i].dm, vec[i].dout);
         chk($sformatf("v%0d_ddr_wr_n", i), line_t'(dwr_addr_q.size() - wr0), line_t'(vec[i].wb_n));
         if (vec[i].wb_n > 0 && dwr_addr_q.size() > wr0) begin
            chk($sformatf("v%0d_wb_addr", i), line_t'(dwr_addr_q[wr0]), line_t'(vec[i].wb_addr));
            chk($sformatf("v%0d_wb_dat", i), dwr_dat_q[wr0], vec[i].wb_dat);
         end
         chk($sformatf("v%0d_ddr_rd_n", i), line_t'(drd_addr_q.size() - rd0), line_t'(vec[i].rd_n));
         if (vec[i].rd_n > 0 && drd_addr_q.size() > rd0)
            chk($sformatf("v%0d_rd_addr", i), line_t'(drd_addr_q[rd0]), line_t'(vec[i].rd_addr));
         chk($sformatf("v%0d_sram_wr_n", i), line_t'(s_wr_n - sw0), line_t'(vec[i].swr_n));
         chk($sformatf("v%0d_sram_addr", i), line_t'(s_last_addr), line_t'(vec[i].s_addr));
         if (vec[i].swr_n > 0) chk($sformatf("v%0d_sram_dm", i), line_t'(s_last_dm), line_t'(vec[i].s_dm));
         if (vec[i].chk_line)
            chk($sformatf("v%0d_sram_line", i), sram_mem[vec[i].s_addr[OFF_W +: INDEX_W]], vec[i].line);
      end

      // flush: dirty sets 3 and 9 written back in ascending order, then both miss
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      fill_data = L5A;
      do_req(1'b1, 32'h000020C0, LA, ALL1, '0);
      do_req(1'b1, 32'h00002240, LB, ALL1, '0);
      wr0 = dwr_addr_q.size(); rd0 = drd_addr_q.size(); a0 = ack_n;
      @(negedge clk); flush_req = 1'b1;
      @(negedge clk); flush_req = 1'b0;
      chk("flush_busy_rise", line_t'(flush_busy), line_t'(1'b1));
      n = 0;
      while (flush_busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("flush_busy_fall", line_t'(flush_busy), '0);
      chk("flush_wb_n", line_t'(dwr_addr_q.size() - wr0), line_t'(2));
      if (dwr_addr_q.size() >= wr0 + 2) begin
         chk("flush_wb0_addr", line_t'(dwr_addr_q[wr0]), line_t'(32'h000020C0));
         chk("flush_wb0_dat", dwr_dat_q[wr0], LA);
         chk("flush_wb1_addr", line_t'(dwr_addr_q[wr0+1]), line_t'(32'h00002240));
         chk("flush_wb1_dat", dwr_dat_q[wr0+1], LB);
      end
      chk("flush_rd_n", line_t'(drd_addr_q.size() - rd0), '0);
      chk("flush_no_ack", line_t'(ack_n - a0), '0);
      rd0 = drd_addr_q.size(); fill_data = LC;
      do_req(1'b0, 32'h00002240, '0, '0, LC);
      chk("post_flush_miss9", line_t'(drd_addr_q.size() - rd0), line_t'(1));
      rd0 = drd_addr_q.size(); fill_data = LD;
      do_req(1'b0, 32'h000020C0, '0, '0, LD);
      chk("post_flush_miss3", line_t'(drd_addr_q.size() - rd0), line_t'(1));
      rd0 = drd_addr_q.size();
      do_req(1'b0, 32'h00002240, '0, '0, LC);
      chk("refilled_hit", line_t'(drd_addr_q.size() - rd0), '0);

      // reset while a fill is outstanding
      @(negedge clk);
      ws_stb = 1'b1; ws_we = 1'b0; ws_addr = 32'h00003300;
      n = 0;
      while (ws_DDRstb !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("fill_started", line_t'(ws_DDRstb), line_t'(1'b1));
      rst = 1'b1; ws_stb = 1'b0;
      @(posedge clk); #1;
      chk("rst_fill_strobes", line_t'({ws_DDRstb, ws_SRAMstb}), '0);
      chk("rst_fill_ack_busy", line_t'({ws_ack, flush_busy}), '0);
      @(negedge clk); rst = 1'b0;
      rd0 = drd_addr_q.size(); fill_data = LE;
      do_req(1'b0, 32'h00002240, '0, '0, LE);
      chk("post_rst_miss", line_t'(drd_addr_q.size() - rd0), line_t'(1));

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at 500us, want finish");
      $fatal(1, "watchdog");
   end
endmodule
